// File: rtl/mem_pkg.sv
// Shared constants and state encoding for the 1024x32 word memory and its copy engine.
package mem_pkg;
    localparam int AW      = 10;
    localparam int DW      = 32;
    localparam int LEN_W   = 11;
    localparam int KEY_W   = 16;
    localparam int MAX_LEN = 1024;
    localparam logic [AW-1:0] PARK_ADDR = 10'd512;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WB
    } state_t;
endpackage

// File: rtl/mem_copy_engine.sv
// Key-gated forward block copy: one read and one write per cycle; the write port
// is parked on a scratch word (data 0) whenever no copy write is in flight.
module mem_copy_engine
    import mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AW-1:0]    req_src,
    input  logic [AW-1:0]    req_dst,
    input  logic [LEN_W-1:0] req_len,
    input  logic [KEY_W-1:0] req_key,
    input  logic [KEY_W-1:0] key_access,
    output logic [AW-1:0]    read_address,
    output logic [AW-1:0]    write_address,
    output logic [DW-1:0]    data_in,
    input  logic [DW-1:0]    data_out,
    output logic             busy,
    output logic             done,
    output logic             err
);
    state_t            state_q, state_d;
    logic [AW-1:0]     src_q, dst_q, wr_addr_q;
    logic [LEN_W-1:0]  len_q, i_q;
    logic              wr_valid_q, done_q, err_q;
    logic              fire, reject;
    logic [AW-1:0]     park_off;

    assign fire = req_valid && req_ready;

    // Offset of the scratch word from dst, modulo the address space; a copy
    // whose destination range reaches it would be clobbered by parking.
    always_comb begin
        park_off = PARK_ADDR - req_dst;
        reject   = (req_len == '0)
                || (req_len > LEN_W'(MAX_LEN))
                || (req_key != key_access)
                || ({1'b0, park_off} < req_len);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (fire && !reject) state_d = RD;
            RD:   if (i_q == len_q - 1'b1) state_d = WB;
            WB:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            i_q        <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= (state_q == WB);
            err_q      <= fire && reject;
            wr_valid_q <= (state_q == RD);
            wr_addr_q  <= dst_q + i_q[AW-1:0];
            if (fire && !reject) begin
                src_q <= req_src;
                dst_q <= req_dst;
                len_q <= req_len;
                i_q   <= '0;
            end else if (state_q == RD) begin
                i_q <= i_q + 1'b1;
            end
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign err          = err_q;
    assign read_address = (state_q == RD) ? (src_q + i_q[AW-1:0]) : '0;

    // Read data from the previous cycle passes straight through to the write port.
    assign write_address = wr_valid_q ? wr_addr_q : PARK_ADDR;
    assign data_in       = wr_valid_q ? data_out  : '0;
endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: behavioural 1024x32 memory plus a word-array copy model.
module tb_mem_copy_engine;
    import mem_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [AW-1:0]    req_src, req_dst;
    logic [LEN_W-1:0] req_len;
    logic [KEY_W-1:0] req_key;
    logic [KEY_W-1:0] key_access = 16'h0032;
    logic [AW-1:0]    read_address, write_address;
    logic [DW-1:0]    data_in, data_out;
    logic             busy, done, err;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem   [1024];
    logic [31:0] model [1024];
    logic        loaded = 1'b0;

    always #5 clk = ~clk;

    mem_copy_engine dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_dst(req_dst), .req_len(req_len), .req_key(req_key),
        .key_access(key_access),
        .read_address(read_address), .write_address(write_address),
        .data_in(data_in), .data_out(data_out),
        .busy(busy), .done(done), .err(err)
    );

    function automatic logic [31:0] init_word(int k);
        if (k == 512) return 32'h0;
        if (k <= 10) return 32'(k);
        return (32'(k) * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // Memory: registered read, unconditional write every clock (no write enable).
    always @(posedge clk) begin
        if (!loaded) begin
            for (int k = 0; k < 1024; k++) mem[k] <= init_word(k);
            loaded <= 1'b1;
        end
        data_out <= mem[read_address];
        mem[write_address] <= data_in;
    end

    // Forward copy in word order; only used for disjoint ranges or dst past src's reads.
    task automatic model_copy(input int src, input int dst, input int len);
        for (int k = 0; k < len; k++) model[(dst + k) % 1024] = model[(src + k) % 1024];
    endtask

    function automatic int count_mem_diffs(output int first);
        int n = 0;
        first = -1;
        for (int k = 0; k < 1024; k++)
            if (mem[k] !== model[k]) begin
                if (first < 0) first = k;
                n++;
            end
        return n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; returns #1 into cycle 1 after the handshake.
    task automatic start_req(input int src, input int dst, input int len, input logic [15:0] key);
        req_src = AW'(src); req_dst = AW'(dst); req_len = LEN_W'(len); req_key = key;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = -1;
        for (int c = 1; c <= limit; c++) begin
            if (done === 1'b1) begin
                cyc = c;
                return;
            end
            step();
        end
    endtask

    task automatic test_reset();
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got ready=%b busy=%b done=%b err=%b exp 1 0 0 0",
                     req_ready, busy, done, err);
        end
        checks++;
        if (read_address !== '0 || write_address !== PARK_ADDR || data_in !== '0) begin
            errors++;
            $display("FAIL reset_ports got ra=%0d wa=%0d din=%0h exp 0 512 0",
                     read_address, write_address, data_in);
        end
    endtask

    task automatic test_contiguous();
        int first;
        int bad = 0;
        start_req(0, 100, 11, 16'h0032);
        model_copy(0, 100, 11);
        for (int c = 1; c <= 14; c++) begin
            checks++;
            if (busy !== (c <= 12) || done !== (c == 13)) begin
                errors++;
                $display("FAIL contig_timing cycle %0d got busy=%b done=%b exp %b %b",
                         c, busy, done, c <= 12, c == 13);
            end
            step();
        end
        for (int j = 0; j <= 10; j++) if (mem[100 + j] !== 32'(j)) bad++;
        checks++;
        if (bad != 0 || mem[512] !== 32'h0) begin
            errors++;
            $display("FAIL contig_data got %0d bad words, mem[512]=%0h exp 0 bad, 0", bad, mem[512]);
        end
        checks++;
        if (count_mem_diffs(first) != 0) begin
            errors++;
            $display("FAIL contig_mem got mem[%0d]=%0h exp %0h", first, mem[first], model[first]);
        end
    endtask

    task automatic test_wrong_key();
        int first;
        start_req(0, 200, 4, 16'h0033);
        checks++;
        if (err !== 1'b1 || req_ready !== 1'b1 || busy !== 1'b0 || write_address !== PARK_ADDR) begin
            errors++;
            $display("FAIL badkey_c1 got err=%b ready=%b busy=%b wa=%0d exp 1 1 0 512",
                     err, req_ready, busy, write_address);
        end
        step();
        checks++;
        if (err !== 1'b0 || write_address !== PARK_ADDR) begin
            errors++;
            $display("FAIL badkey_c2 got err=%b wa=%0d exp 0 512", err, write_address);
        end
        step();
        checks++;
        if (count_mem_diffs(first) != 0) begin
            errors++;
            $display("FAIL badkey_mem got mem[%0d]=%0h exp %0h", first, mem[first], model[first]);
        end
    endtask

    task automatic test_zero_and_park();
        int first, cyc;
        start_req(0, 150, 0, 16'h0032);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len got err=%b busy=%b exp 1 0", err, busy);
        end
        step();
        start_req(0, 510, 3, 16'h0032);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL park_hit got err=%b busy=%b exp 1 0", err, busy);
        end
        step();
        start_req(0, 150, 1025, 16'h0032);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL len_1025 got err=%b busy=%b exp 1 0", err, busy);
        end
        step();
        start_req(20, 510, 2, 16'h0032);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL park_edge got err=%b busy=%b exp 0 1", err, busy);
        end
        model_copy(20, 510, 2);
        wait_done(20, cyc);
        checks++;
        if (cyc != 4) begin
            errors++;
            $display("FAIL park_edge_done got cycle %0d exp 4", cyc);
        end
        checks++;
        if (count_mem_diffs(first) != 0) begin
            errors++;
            $display("FAIL park_edge_mem got mem[%0d]=%0h exp %0h", first, mem[first], model[first]);
        end
    endtask

    task automatic test_wrap();
        int cyc, bad = 0;
        start_req(0, 1020, 8, 16'h0032);
        model_copy(0, 1020, 8);
        wait_done(20, cyc);
        checks++;
        if (cyc != 10) begin
            errors++;
            $display("FAIL wrap_done got cycle %0d exp 10", cyc);
        end
        step();
        for (int j = 0; j < 4; j++) begin
            if (mem[1020 + j] !== 32'(j)) bad++;
            if (mem[j] !== 32'(j + 4)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wrap_data got %0d bad words exp 0 (mem[0]=%0h mem[1020]=%0h)",
                     bad, mem[0], mem[1020]);
        end
    endtask

    task automatic test_back_to_back();
        int first, cyc;
        req_src = 10'd40; req_dst = 10'd600; req_len = 11'd4; req_key = 16'h0032;
        req_valid = 1'b1;
        step();
        req_src = 10'd60; req_dst = 10'd700; req_len = 11'd5;
        model_copy(40, 600, 4);
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if (req_ready !== (c == 6) || busy !== (c <= 5) || done !== (c == 6)) begin
                errors++;
                $display("FAIL b2b_cycle %0d got ready=%b busy=%b done=%b exp %b %b %b",
                         c, req_ready, busy, done, c == 6, c <= 5, c == 6);
            end
            step();
        end
        req_valid = 1'b0;
        model_copy(60, 700, 5);
        checks++;
        if (busy !== 1'b1 || read_address !== 10'd60) begin
            errors++;
            $display("FAIL b2b_accept got busy=%b ra=%0d exp 1 60", busy, read_address);
        end
        wait_done(20, cyc);
        checks++;
        if (cyc != 7) begin
            errors++;
            $display("FAIL b2b_done got cycle %0d exp 7", cyc);
        end
        checks++;
        if (count_mem_diffs(first) != 0) begin
            errors++;
            $display("FAIL b2b_mem got mem[%0d]=%0h exp %0h", first, mem[first], model[first]);
        end
    endtask

    task automatic test_reset_mid();
        int first;
        int saw_done = 0;
        start_req(0, 300, 11, 16'h0032);
        repeat (4) step();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0 || read_address !== '0
            || write_address !== PARK_ADDR || data_in !== '0) begin
            errors++;
            $display("FAIL rst_mid_async got busy=%b ready=%b done=%b ra=%0d wa=%0d din=%0h exp 0 1 0 0 512 0",
                     busy, req_ready, done, read_address, write_address, data_in);
        end
        // Writes committed at the ends of cycles 2, 3 and 4 survive.
        model_copy(0, 300, 3);
        step();
        step();
        rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (done === 1'b1 || busy === 1'b1) saw_done++;
            step();
        end
        checks++;
        if (saw_done != 0) begin
            errors++;
            $display("FAIL rst_mid_quiet got %0d done/busy cycles exp 0", saw_done);
        end
        checks++;
        if (count_mem_diffs(first) != 0) begin
            errors++;
            $display("FAIL rst_mid_mem got mem[%0d]=%0h exp %0h", first, mem[first], model[first]);
        end
    endtask

    task automatic test_random();
        int src, dst, len, first, cyc;
        logic [15:0] key;
        bit exp_rej;
        for (int it = 0; it < 30; it++) begin
            int r = $urandom_range(0, 19);
            if (r == 0) len = 0;
            else if (r == 1) len = 1025;
            else len = $urandom_range(1, 48);
            key = ($urandom_range(0, 4) == 0) ? 16'(16'h0032 ^ (1 << $urandom_range(0, 15))) : 16'h0032;
            src = $urandom_range(0, 1023);
            do dst = $urandom_range(0, 1023);
            while (len >= 1 && len <= 1024 &&
                   (((dst - src + 1024) % 1024) < len || ((src - dst + 1024) % 1024) < len));
            exp_rej = (len == 0) || (len > 1024) || (key != 16'h0032);
            if (!exp_rej)
                for (int k = 0; k < len; k++) if ((dst + k) % 1024 == 512) exp_rej = 1'b1;
            start_req(src, dst, len, key);
            if (exp_rej) begin
                checks++;
                if (err !== 1'b1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_reject it %0d src=%0d dst=%0d len=%0d got err=%b busy=%b exp 1 0",
                             it, src, dst, len, err, busy);
                end
                step();
            end else begin
                model_copy(src, dst, len);
                wait_done(len + 10, cyc);
                checks++;
                if (cyc != len + 2) begin
                    errors++;
                    $display("FAIL rand_done it %0d len=%0d got cycle %0d exp %0d", it, len, cyc, len + 2);
                end
            end
            checks++;
            if (count_mem_diffs(first) != 0) begin
                errors++;
                $display("FAIL rand_mem it %0d got mem[%0d]=%0h exp %0h", it, first, mem[first], model[first]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired, simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_src = '0; req_dst = '0; req_len = '0; req_key = '0;
        for (int k = 0; k < 1024; k++) model[k] = init_word(k);
        repeat (3) step();
        rst = 1'b0;
        step();
        test_reset();
        test_contiguous();
        test_wrong_key();
        test_zero_and_park();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Key-gated block-copy sequencer sitting directly upstream of the 1024×32 word memory, driving its primary port pair (`read_address`, `write_address`, `data_in`, `data_out`). It accepts one copy request at a time over a valid/ready handshake and checks the request key against the memory's `key_access`. It then streams `len` words from `src` to `dst`, one read and one write per cycle. The memory has no write enable, so the engine parks the write port on a reserved scratch word whenever it is not writing.

## Interface
- `AW`, 10: word address width.
- `DW`, 32: data width.
- `LEN_W`, 11: length width; 1..1024 words.
- `KEY_W`, 16: key width.
- `PARK_ADDR`, 10'd512: reserved scratch address; receives 0 on every non-copy cycle.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  engine idle and able to accept.
- `req_src`  in  AW  first source word.
- `req_dst`  in  AW  first destination word.
- `req_len`  in  LEN_W  word count.
- `req_key`  in  KEY_W  requester key.
- `key_access`  in  KEY_W  key published by the memory.
- `read_address`  out  AW  to memory read port.
- `write_address`  out  AW  to memory write port.
- `data_in`  out  DW  to memory write data.
- `data_out`  in  DW  memory read data; valid one cycle after its address.
- `busy`  out  1  high while not IDLE.
- `done`  out  1  one-cycle pulse; copy complete.
- `err`  out  1  one-cycle pulse; request rejected.

## Operation
- States: IDLE, RD, WB.
- IDLE:
  - `req_ready`=1.
  - Handshake fires on `req_valid && req_ready`.
- Reject conditions, checked on the handshake:
  - `req_len`==0.
  - `req_len`>1024.
  - `req_key`!=`key_access`.
  - Destination range covers `PARK_ADDR`, i.e. `(PARK_ADDR - req_dst) mod 1024 < req_len`.
- On reject: `err`=1 next cycle, stay IDLE, no memory write.
- On accept: latch src, dst, len; counter i=0; go to RD.
- RD:
  - `read_address` = src+i, mod 2^AW (wraps 1023→0).
  - i increments each cycle.
  - After the read with i=len-1, go to WB.
- Write stage:
  - Registered `wr_valid_q` and `wr_addr_q` = dst+i from the previous cycle.
  - While `wr_valid_q`: `write_address`=`wr_addr_q`, `data_in`=`data_out` (combinational pass-through).
  - Otherwise: `write_address`=`PARK_ADDR`, `data_in`=0.
- WB: performs the final write; next state IDLE with `done`=1 for one cycle.
- `read_address` outside RD is held at 0. A read there is harmless.
- Requests seen while busy are ignored; `req_ready`=0.
- Overlap handling:
  - Copy is strictly forward.
  - Correct for non-overlapping ranges and for dst ≤ src+1. The read at a given edge sees pre-write data from the same edge.
  - For other overlaps, results are undefined; the requester is responsible.
- Reset values: `req_ready`=1 after reset release, `busy`=0, `done`=0, `err`=0, `read_address`=0, `write_address`=`PARK_ADDR`, `data_in`=0, state IDLE, counters 0.
- Reset mid-copy:
  - Immediate return to IDLE with the parked write port.
  - Words already written remain; no completion pulse.

## Timing
- Handshake at edge E0.
- Reads in cycles 1..len.
- Writes in cycles 2..len+1.
- `done` and `req_ready` high in cycle len+2. A new request may be accepted at the end of that cycle.
- Throughput: 1 word/cycle; overhead 2 cycles per request.
- `err` appears in cycle 1 after a rejected handshake; `req_ready` stays 1.
- `busy` high in cycles 1..len+1.
- Combinational path `data_out`→`data_in` must close within one clock.

## Structure
- Shared package `mem_pkg` holds:
  - `AW`, `DW`, `KEY_W`, `LEN_W`, `PARK_ADDR`.
  - The state enum (IDLE/RD/WB).
- The memory instance and this engine both import it.
- Single module; no sub-module warranted. The address counter and write stage are a few registers each.

## Test plan
- Contiguous copy, memory preloaded with mem[k]=k for k=0..10:
  - Stimulus: src=0, dst=100, len=11, key=0x0032.
  - Response: mem[100..110]=0..10; `done` in cycle 13 after E0; `busy` high cycles 1..12; mem[512]=0.
- Wrong key:
  - Stimulus: key=0x0033, src=0, dst=200, len=4.
  - Response: `err` pulse in cycle 1; mem[200..203] unchanged; only `PARK_ADDR` written.
- Zero length and park collision:
  - Stimulus: len=0; then dst=510, len=3.
  - Response: each gives `err`, no copy. dst=510, len=2 is accepted.
- Address wrap:
  - Stimulus: src=0, dst=1020, len=8.
  - Response: mem[1020..1023]=0,1,2,3 and mem[0..3]=4,5,6,7; `done` in cycle 10.
- Back-to-back and busy:
  - Stimulus: hold `req_valid` through a len=4 copy with a second request queued.
  - Response: second request accepted only in cycle 6.
- Reset mid-copy:
  - Stimulus: assert `rst` in cycle 5 of a len=11 copy.
  - Response: outputs at reset values asynchronously; no `done`; exactly the words written before reset are changed.
